// File: rtl/mult_hilo_unit.sv
// rtl/mult_hilo_unit.sv - multiplier issue/writeback stage with HI/LO registers and read interlock
// Optional define HILO_FWD_EN forwards the product to MFHI/MFLO during the completion cycle.
module mult_hilo_unit #(
  parameter int MULT_LATENCY = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [32:0] mul_a,
  output logic [32:0] mul_b,
  input  logic [65:0] mul_p,
  output logic        busy,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] mt_data,
  input  logic        rd_req,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        rd_stall
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MULT_LATENCY - 1);

  state_t      state, state_nxt;
  logic [3:0]  count, count_nxt;
  logic [31:0] hi, lo, hi_nxt, lo_nxt;
  logic        done;
  logic        unused_mul_p_top;

  // The two top product bits only matter for 33x33 corner cases the ISA never observes.
  assign unused_mul_p_top = ^mul_p[65:64];

  // A restart in the final cycle cancels the writeback of the product being dropped.
  assign done = (state == BUSY) && (count == 4'd0) && !op_valid;
  assign busy = (state == BUSY);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    hi_nxt    = hi;
    lo_nxt    = lo;
    if (op_valid) begin
      state_nxt = BUSY;
      count_nxt = CNT_LOAD;
    end else if (state == BUSY) begin
      if (count == 4'd0) state_nxt = IDLE;
      else               count_nxt = count - 4'd1;
    end
    if (done) begin
      hi_nxt = mul_p[63:32];
      lo_nxt = mul_p[31:0];
    end
    if (mthi_we) hi_nxt = mt_data;
    if (mtlo_we) lo_nxt = mt_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= 4'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      mul_a <= 33'd0;
      mul_b <= 33'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      if (op_valid) begin
        mul_a <= {op_signed & op_a[31], op_a};
        mul_b <= {op_signed & op_b[31], op_b};
      end
    end
  end

`ifdef HILO_FWD_EN
  assign rd_stall = rd_req & busy & ~done;
  always_comb begin
    rd_data = rd_sel ? hi : lo;
    if (done) rd_data = rd_sel ? mul_p[63:32] : mul_p[31:0];
  end
`else
  assign rd_stall = rd_req & busy;
  assign rd_data  = rd_sel ? hi : lo;
`endif

endmodule

// File: tb/tb_mult_hilo_unit.sv
// tb/tb_mult_hilo_unit.sv - scoreboard bench for mult_hilo_unit
module tb_mult_hilo_unit;

  logic        clk = 1'b0;
  logic        reset, op_valid, op_signed, mthi_we, mtlo_we, rd_req, rd_sel;
  logic [31:0] op_a, op_b, mt_data, rd_data;
  logic [32:0] mul_a, mul_b;
  logic [65:0] mul_p;
  logic        busy, rd_stall;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb_q[$];

`ifdef HILO_FWD_EN
  localparam int EXP_STALL = 5;
`else
  localparam int EXP_STALL = 6;
`endif

  always #5 clk = ~clk;

  // Multiplier core model: 33x33 signed product, sign-extended to 66 bits.
  assign mul_p = {{33{mul_a[32]}}, mul_a} * {{33{mul_b[32]}}, mul_b};

  mult_hilo_unit #(.MULT_LATENCY(6)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_signed(op_signed),
    .op_a(op_a), .op_b(op_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .busy(busy), .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_data(mt_data),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data), .rd_stall(rd_stall)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rd_req && !rd_stall) begin
      if (sb_q.size() == 0) check("sb_underflow", 64'd1, 64'd0);
      else check("rd_data", 64'(rd_data), 64'(sb_q.pop_front()));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op_signed = sgn; op_a = a; op_b = b;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic do_read(input logic sel, input logic [31:0] exp, output int stalls);
    rd_req = 1'b1; rd_sel = sel; sb_q.push_back(exp); stalls = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!rd_stall) break;
      stalls++;
    end
    if (stalls >= 40) check("rd_timeout", 64'(stalls), 64'd0);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, st;
    reset = 1'b1; op_valid = 1'b0; op_signed = 1'b0; op_a = '0; op_b = '0;
    mthi_we = 1'b0; mtlo_we = 1'b0; mt_data = '0; rd_req = 1'b0; rd_sel = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_mul_a", 64'(mul_a), 64'd0);
    do_read(1'b0, 32'h0, st);
    check("reset_stall", 64'(st), 64'd0);
    do_read(1'b1, 32'h0, st);

    // MULT -3 x 5
    start(1'b1, 32'hFFFFFFFD, 32'd5);
    check("t1_mul_a", 64'(mul_a), 64'h1_FFFFFFFD);
    check("t1_mul_b", 64'(mul_b), 64'h0_00000005);
    count_busy(n);
    check("t1_busy_cycles", 64'(n), 64'd6);
    do_read(1'b1, 32'hFFFFFFFF, st);
    do_read(1'b0, 32'hFFFFFFF1, st);

    // MULTU vs MULT of FFFFFFFF x 2
    start(1'b0, 32'hFFFFFFFF, 32'd2);
    check("t2u_mul_a", 64'(mul_a), 64'h0_FFFFFFFF);
    count_busy(n);
    do_read(1'b1, 32'h00000001, st);
    do_read(1'b0, 32'hFFFFFFFE, st);
    start(1'b1, 32'hFFFFFFFF, 32'd2);
    check("t2s_mul_a", 64'(mul_a), 64'h1_FFFFFFFF);
    check("t2s_mul_b", 64'(mul_b), 64'h0_00000002);
    count_busy(n);
    do_read(1'b1, 32'hFFFFFFFF, st);
    do_read(1'b0, 32'hFFFFFFFE, st);

    // Reset three cycles into 9x9 discards the product
    start(1'b0, 32'd9, 32'd9);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t5_busy", 64'(busy), 64'd0);
    tick();
    repeat (8) tick();
    do_read(1'b0, 32'h0, st);
    do_read(1'b1, 32'h0, st);

    // Read in the accept cycle returns old LO; MFLO the next cycle stalls
    op_valid = 1'b1; op_signed = 1'b0; op_a = 32'd7; op_b = 32'd6;
    rd_req = 1'b1; rd_sel = 1'b0; sb_q.push_back(32'h0);
    @(negedge clk);
    check("t3_accept_stall", 64'(rd_stall), 64'd0);
    tick();
    op_valid = 1'b0;
    do_read(1'b0, 32'h0000002A, st);
    check("t3_stall_cycles", 64'(st), 64'(EXP_STALL));

    // Restart three cycles in: first product never lands, busy continuous
    start(1'b0, 32'd2, 32'd3);
    rd_sel = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 6) check("t4_no_old_wb", 64'(rd_data), 64'h2A);
      if (!busy) break;
      n++;
      tick();
      if (k == 1) begin op_valid = 1'b1; op_a = 32'd4; op_b = 32'd5; end
      else op_valid = 1'b0;
    end
    tick();
    check("t4_busy_cycles", 64'(n), 64'd9);
    do_read(1'b0, 32'h00000014, st);
    do_read(1'b1, 32'h00000000, st);

    // MTHI with a simultaneous read returns the pre-write HI
    mthi_we = 1'b1; mt_data = 32'h55555555;
    do_read(1'b1, 32'h0, st);
    mthi_we = 1'b0;
    do_read(1'b1, 32'h55555555, st);

    // MTLO on the completion edge of 1x1 wins LO; product still writes HI
    start(1'b0, 32'd1, 32'd1);
    repeat (5) tick();
    mtlo_we = 1'b1; mt_data = 32'h12345678;
    tick();
    mtlo_we = 1'b0;
    check("t6_idle", 64'(busy), 64'd0);
    do_read(1'b0, 32'h12345678, st);
    do_read(1'b1, 32'h00000000, st);

    // MTHI mid-busy is overwritten by the product
    start(1'b0, 32'd1, 32'd1);
    tick(); tick();
    mthi_we = 1'b1; mt_data = 32'hAAAA0000;
    tick();
    mthi_we = 1'b0;
    count_busy(n);
    do_read(1'b1, 32'h00000000, st);
    do_read(1'b0, 32'h00000001, st);

    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
